hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and bubbles for load-use, cache misses, taken branches and halt.
// Control outputs are combinational from the current state and inputs; state and counters update on clk.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        IDEX_MemRead,
    input  logic [3:0]  IDEX_DstReg,
    input  logic [3:0]  IFID_SrcReg1,
    input  logic [3:0]  IFID_SrcReg2,
    input  logic        IFID_UsesSrc2,
    input  logic        BranchTaken,
    input  logic        IMissStall,
    input  logic        DMissStall,
    input  logic        Halt_WB,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        nop,
    output logic        pipe_wen,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic [7:0]  flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DMISS  = 2'b01,
        LDUSE  = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic load_use;
    logic src1_hit;
    logic src2_hit;
    logic stall_inc;

    // R0 is hardwired zero, so a load targeting it never creates a hazard.
    assign src1_hit = (IDEX_DstReg == IFID_SrcReg1);
    assign src2_hit = IFID_UsesSrc2 & (IDEX_DstReg == IFID_SrcReg2);
    assign load_use = IDEX_MemRead & (IDEX_DstReg != 4'd0) & (src1_hit | src2_hit);

    assign state = cur_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            HALTED: nxt_state = HALTED;
            DMISS: begin
                if (Halt_WB)         nxt_state = HALTED;
                else if (DMissStall) nxt_state = DMISS;
                else                 nxt_state = RUN;
            end
            default: begin
                // RUN and LDUSE share the same exit rules.
                if (Halt_WB)         nxt_state = HALTED;
                else if (DMissStall) nxt_state = DMISS;
                else if (load_use)   nxt_state = LDUSE;
                else                 nxt_state = RUN;
            end
        endcase
    end

    always_comb begin
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        ifid_flush = 1'b0;
        nop        = 1'b0;
        pipe_wen   = 1'b1;
        if (cur_state == HALTED) begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            pipe_wen = 1'b0;
            nop      = 1'b1;
        end else if (DMissStall) begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            pipe_wen = 1'b0;
        end else if (load_use) begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            nop      = 1'b1;
        end else if (BranchTaken) begin
            ifid_flush = 1'b1;
        end else if (IMissStall) begin
            // Hold fetch, feed nops into IF/ID and let the back end drain.
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign stall_inc = ~pc_wen & (cur_state != HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
            flush_count <= 8'd0;
        end else begin
            if (stall_inc && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            if (ifid_flush && flush_count != 8'hFF) begin
                flush_count <= flush_count + 8'd1;
            end
        end
    end

endmodule
